demux_router: RTL

Four-way stream demultiplexer: each input beat carries a 2-bit select and a data word, and the block routes it into one of four per-channel buffers. Each output channel drains through its own valid/ready handshake. The block sits downstream of a single producer and feeds four independent consumers. It is the distribution-side counterpart of the 4:1 selection mux.

---
 rtl/demux_router.sv | 126 ++++++++++++
 1 files changed

// File: rtl/demux_router.sv
// demux_router: 4-way stream demultiplexer with one FIFO per output channel.
// Ports: clk/rst (sync, active-high); sel/in_data/in_valid/in_ready input
// beat; out_data/out_valid/out_ready per-channel drain; idle = all empty.
// Optional DEMUX_STATS_EN adds stat_cnt (16-bit saturating pops per channel).
module demux_router #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     sel,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic           idle
`ifdef DEMUX_STATS_EN
  ,
  output logic [63:0]    stat_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q  [4][DEPTH];
  logic [W-1:0]  mem_d  [4][DEPTH];
  logic [PW-1:0] rptr_q [4];
  logic [PW-1:0] rptr_d [4];
  logic [PW-1:0] wptr_q [4];
  logic [PW-1:0] wptr_d [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];

  logic       push;
  logic [3:0] wr;
  logic [3:0] pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at the selected channel's registered count.
  always_comb begin
    in_ready = (cnt_q[sel] != CW'(DEPTH));
    push     = in_valid & in_ready;
    wr       = '0;
    pop      = '0;
    out_data = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (cnt_q[k] != '0);
      pop[k]       = out_valid[k] & out_ready[k];
      wr[k]        = push & (sel == 2'(k));
      if (out_valid[k]) begin
        out_data[k*W +: W] = mem_q[k][rptr_q[k]];
      end
    end
  end

  assign idle = ~|out_valid;

  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (wr[k]) begin
        mem_d[k][wptr_q[k]] = in_data;
        wptr_d[k] = ptr_inc(wptr_q[k]);
      end
      if (pop[k]) begin
        rptr_d[k] = ptr_inc(rptr_q[k]);
      end
      // Push and pop together leave the count unchanged.
      unique case ({wr[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        rptr_q[k] <= '0;
        wptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      mem_q  <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] stat_q [4];
  logic [15:0] stat_d [4];

  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < 4; k++) begin
      if (pop[k] && stat_q[k] != 16'hFFFF) begin
        stat_d[k] = stat_q[k] + 16'd1;
      end
      stat_cnt[k*16 +: 16] = stat_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        stat_q[k] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end
`endif

endmodule
